// File: rtl/core6502_pkg.sv
// Shared definitions for the 6502-style core: one-hot timing-state encodings,
// used by the timing generator, the random-logic block and the bench.
package core6502_pkg;

    localparam int NUM_TSTATES = 7;

    localparam logic [NUM_TSTATES-1:0] ST_T0 = 7'b000_0001;
    localparam logic [NUM_TSTATES-1:0] ST_T1 = 7'b000_0010;
    localparam logic [NUM_TSTATES-1:0] ST_T2 = 7'b000_0100;
    localparam logic [NUM_TSTATES-1:0] ST_T3 = 7'b000_1000;
    localparam logic [NUM_TSTATES-1:0] ST_T4 = 7'b001_0000;
    localparam logic [NUM_TSTATES-1:0] ST_T5 = 7'b010_0000;
    localparam logic [NUM_TSTATES-1:0] ST_T6 = 7'b100_0000;

    // Enum literals carry an S_ prefix so they never collide with the T6 port.
    typedef enum logic [NUM_TSTATES-1:0] {
        S_T0 = ST_T0,
        S_T1 = ST_T1,
        S_T2 = ST_T2,
        S_T3 = ST_T3,
        S_T4 = ST_T4,
        S_T5 = ST_T5,
        S_T6 = ST_T6
    } tstate_e;

endpackage

// File: rtl/tstate_gen.sv
// Instruction timing-state generator: sequences T0..T6 and drives the
// active-low timing lines, SYNC and the IR load strobe for the decode PLA.
//
// state | meaning
// ------+------------------------------------------------------------
// S_T0  | last cycle of an instruction (overlaps next opcode fetch)
// S_T1  | opcode fetch cycle (SYNC high)
// S_T2  | first operand cycle; two-cycle ops also assert n_T0 here
// S_T3  | third cycle of longer instructions
// S_T4  | fourth cycle
// S_T5  | fifth cycle
// S_T6  | extra read-modify-write cycle
module tstate_gen
    import core6502_pkg::*;
(
    input  logic PHI0,
    input  logic RES,
    input  logic RDY,
    input  logic WR,
    input  logic TWOCYCLE,
    input  logic ENDS,
    output logic n_T0,
    output logic n_T1X,
    output logic n_T2,
    output logic n_T3,
    output logic n_T4,
    output logic n_T5,
    output logic T6,
    output logic SYNC,
    output logic IR_LD
);

    tstate_e state;
    tstate_e state_nxt;
    logic    adv;

    // Writes never stall, so RDY only gates read cycles.
    assign adv = RDY | WR;

    // State register; reset aborts any instruction and parks in T0.
    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES) begin
            state <= S_T0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: hold when stalled; illegal encodings recover to T0 even when stalled.
    always_comb begin
        state_nxt = state;
        case (state)
            S_T0: if (adv) state_nxt = S_T1;
            S_T1: if (adv) state_nxt = S_T2;
            S_T2: begin
                if (adv) begin
                    if (TWOCYCLE)  state_nxt = S_T1;
                    else if (ENDS) state_nxt = S_T0;
                    else           state_nxt = S_T3;
                end
            end
            S_T3: if (adv) state_nxt = ENDS ? S_T0 : S_T4;
            S_T4: if (adv) state_nxt = ENDS ? S_T0 : S_T5;
            S_T5: if (adv) state_nxt = ENDS ? S_T0 : S_T6;
            S_T6: if (adv) state_nxt = S_T0;
            default: state_nxt = S_T0;
        endcase
    end

    // Output decode from the registered state; two-cycle ops overlap T0 with T2.
    always_comb begin
        n_T0  = 1'b1;
        n_T1X = 1'b1;
        n_T2  = 1'b1;
        n_T3  = 1'b1;
        n_T4  = 1'b1;
        n_T5  = 1'b1;
        T6    = 1'b0;
        SYNC  = 1'b0;
        IR_LD = 1'b0;
        case (state)
            S_T0: n_T0 = 1'b0;
            S_T1: begin
                n_T1X = 1'b0;
                SYNC  = 1'b1;
                IR_LD = adv;
            end
            S_T2: begin
                n_T2 = 1'b0;
                if (TWOCYCLE) n_T0 = 1'b0;
            end
            S_T3: n_T3 = 1'b0;
            S_T4: n_T4 = 1'b0;
            S_T5: n_T5 = 1'b0;
            S_T6: T6   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tstate_gen.sv
// Directed bench for tstate_gen: a table of per-cycle inputs and the
// hand-derived timing state for that cycle, plus a reset-abort sequence.
module tb_tstate_gen;

    logic PHI0 = 1'b0;
    logic RES, RDY, WR, TWOCYCLE, ENDS;
    logic n_T0, n_T1X, n_T2, n_T3, n_T4, n_T5, T6, SYNC, IR_LD;

    int n_checks = 0;
    int n_pass   = 0;

    tstate_gen dut (
        .PHI0(PHI0), .RES(RES), .RDY(RDY), .WR(WR),
        .TWOCYCLE(TWOCYCLE), .ENDS(ENDS),
        .n_T0(n_T0), .n_T1X(n_T1X), .n_T2(n_T2), .n_T3(n_T3),
        .n_T4(n_T4), .n_T5(n_T5), .T6(T6), .SYNC(SYNC), .IR_LD(IR_LD)
    );

    always #5 PHI0 = ~PHI0;

    typedef struct {
        logic rdy;
        logic wr;
        logic tc;
        logic ends;
        int   st;   // expected timing state (0..6) during this cycle
    } vec_t;

    vec_t vecs[$];

    // Expected line pattern {n_T0,n_T1X,n_T2,n_T3,n_T4,n_T5,T6,SYNC,IR_LD}.
    function automatic logic [8:0] exp_lines(int st, logic tc, logic rdy, logic wr);
        logic [8:0] e;
        e[8] = !(st == 0 || (st == 2 && tc));
        e[7] = (st != 1);
        e[6] = (st != 2);
        e[5] = (st != 3);
        e[4] = (st != 4);
        e[3] = (st != 5);
        e[2] = (st == 6);
        e[1] = (st == 1);
        e[0] = (st == 1) && (rdy || wr);
        return e;
    endfunction

    function automatic logic [8:0] act_lines();
        return {n_T0, n_T1X, n_T2, n_T3, n_T4, n_T5, T6, SYNC, IR_LD};
    endfunction

    task automatic check(string name, logic [8:0] exp);
        logic [8:0] act;
        act = act_lines();
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic add(logic rdy, logic wr, logic tc, logic ends, int st);
        vec_t v;
        v.rdy = rdy; v.wr = wr; v.tc = tc; v.ends = ends; v.st = st;
        vecs.push_back(v);
    endtask

    initial begin
        // Long instruction ending in T5
        add(1,0,0,0,0); add(1,0,0,0,1); add(1,0,0,0,2); add(1,0,0,0,3);
        add(1,0,0,0,4); add(1,0,0,1,5); add(1,0,0,0,0);
        // RMW with ignored ENDS in T1/T6 and TWOCYCLE in T3
        add(1,0,0,1,1); add(1,0,0,0,2); add(1,0,1,0,3); add(1,0,0,0,4);
        add(1,0,0,0,5); add(1,0,0,1,6); add(1,0,0,0,0); add(1,0,0,0,1);
        // Two-cycle instructions back to back; TWOCYCLE beats ENDS
        add(1,0,1,1,2); add(1,0,0,0,1); add(1,0,1,0,2); add(1,0,0,0,1);
        add(1,0,0,1,2); add(1,0,0,0,0); add(1,0,0,0,1);
        // Read stall in T3 for 3 cycles
        add(1,0,0,0,2); add(0,0,0,1,3); add(0,0,0,1,3); add(0,0,0,1,3);
        add(1,0,0,0,3); add(1,0,0,1,4); add(1,0,0,0,0); add(1,0,0,0,1);
        // Same stall but a write cycle: no hold
        add(1,0,0,0,2); add(0,1,0,0,3); add(1,0,0,1,4); add(1,0,0,0,0);
        // Fetch stall in T1, then a stalled T0 and a stalled two-cycle T2
        add(0,0,0,0,1); add(0,0,0,0,1); add(1,0,0,0,1); add(0,0,1,0,2);
        add(1,0,0,1,2); add(0,0,0,0,0); add(1,0,0,0,0); add(1,0,0,0,1);

        RES = 1'b1; RDY = 1'b1; WR = 1'b0; TWOCYCLE = 1'b0; ENDS = 1'b0;
        #1;
        check("reset_state", exp_lines(0, 0, 1, 0));
        @(negedge PHI0);
        @(negedge PHI0);
        RES = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            RDY = vecs[i].rdy; WR = vecs[i].wr;
            TWOCYCLE = vecs[i].tc; ENDS = vecs[i].ends;
            #1;
            check($sformatf("vec%0d_T%0d", i, vecs[i].st),
                  exp_lines(vecs[i].st, vecs[i].tc, vecs[i].rdy, vecs[i].wr));
            @(negedge PHI0);
        end

        // Last vector left the design in T2; walk to T4 then reset mid-cycle.
        RDY = 1'b1; WR = 1'b0; TWOCYCLE = 1'b0; ENDS = 1'b0;
        #1;
        check("pre_reset_T2", exp_lines(2, 0, 1, 0));
        @(negedge PHI0);
        @(negedge PHI0);
        #1;
        check("pre_reset_T4", exp_lines(4, 0, 1, 0));
        #1;
        RES = 1'b1;
        #1;
        check("reset_mid_T4", exp_lines(0, 0, 1, 0));
        ENDS = 1'b1; TWOCYCLE = 1'b1;
        @(negedge PHI0);
        @(negedge PHI0);
        #1;
        check("reset_held", exp_lines(0, 1, 1, 0));
        ENDS = 1'b0; TWOCYCLE = 1'b0;
        RES = 1'b0;
        @(posedge PHI0);
        #1;
        check("release_to_T1", exp_lines(1, 0, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
